// File: rtl/vtg_pkg.sv
// vtg_pkg: shared types, widths and config validity rule for the video timing generator.
package vtg_pkg;

    localparam int VTG_X_BITS = 13;
    localparam int VTG_Y_BITS = 13;

    typedef logic [VTG_X_BITS-1:0] x_t;
    typedef logic [VTG_Y_BITS-1:0] y_t;

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_PEND} vtg_state_e;

    typedef struct packed {
        x_t   h_total;
        x_t   h_active;
        x_t   h_fp;
        x_t   h_sync;
        y_t   v_total;
        y_t   v_active;
        y_t   v_fp;
        y_t   v_sync;
        logic hs_pol;
        logic vs_pol;
    } vtg_cfg_t;

    // Two guard bits keep the porch sums exact for any field values.
    function automatic logic vtg_cfg_ok(input vtg_cfg_t c);
        logic [VTG_X_BITS+1:0] h_sum;
        logic [VTG_Y_BITS+1:0] v_sum;
        h_sum = {2'b00, c.h_active} + {2'b00, c.h_fp} + {2'b00, c.h_sync};
        v_sum = {2'b00, c.v_active} + {2'b00, c.v_fp} + {2'b00, c.v_sync};
        return c.h_total > x_t'(1) && c.v_total > y_t'(1) &&
               c.h_active != '0 && c.v_active != '0 &&
               c.h_sync != '0 && c.v_sync != '0 &&
               h_sum <= {2'b00, c.h_total} && v_sum <= {2'b00, c.v_total};
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: config inputs and raster outputs of the timing generator.
interface video_timing_gen_if #(
    parameter int X_BITS = vtg_pkg::VTG_X_BITS,
    parameter int Y_BITS = vtg_pkg::VTG_Y_BITS
);
    logic [X_BITS-1:0] cfg_h_total, cfg_h_active, cfg_h_fp, cfg_h_sync;
    logic [Y_BITS-1:0] cfg_v_total, cfg_v_active, cfg_v_fp, cfg_v_sync;
    logic              cfg_hs_pol, cfg_vs_pol, cfg_load, cfg_pending, cfg_err;
    logic [X_BITS-1:0] x, total_active_pix;
    logic [Y_BITS-1:0] y, total_active_lines;
    logic              hn_out, vn_out, den_out, frame_start;

    modport master (
        input  cfg_h_total, cfg_h_active, cfg_h_fp, cfg_h_sync,
        input  cfg_v_total, cfg_v_active, cfg_v_fp, cfg_v_sync,
        input  cfg_hs_pol, cfg_vs_pol, cfg_load,
        output cfg_pending, cfg_err, x, y, hn_out, vn_out, den_out, frame_start,
        output total_active_pix, total_active_lines
    );

    modport slave (
        output cfg_h_total, cfg_h_active, cfg_h_fp, cfg_h_sync,
        output cfg_v_total, cfg_v_active, cfg_v_fp, cfg_v_sync,
        output cfg_hs_pol, cfg_vs_pol, cfg_load,
        input  cfg_pending, cfg_err, x, y, hn_out, vn_out, den_out, frame_start,
        input  total_active_pix, total_active_lines
    );
endinterface

// File: rtl/vtg_axis_counter.sv
// vtg_axis_counter: one raster axis; wraps against the running total and reports
// active/sync qualifiers for the count it will hold after this clock.
module vtg_axis_counter #(
    parameter int W = 13
) (
    input  logic         clk_in,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         step_i,
    input  logic [W-1:0] total_i,
    input  logic [W-1:0] active_i,
    input  logic [W-1:0] fp_i,
    input  logic [W-1:0] sync_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o,
    output logic         active_o,
    output logic         sync_o
);
    logic [W-1:0] count_q, count_d;
    logic [W+1:0] count_x, sync_lo, sync_hi;

    assign wrap_o  = count_q == total_i - 1'b1;
    assign count_o = count_q;

    // active/fp/sync describe the geometry in effect next cycle, so a freshly
    // applied mode gets correct qualifiers on its very first pixel.
    always_comb begin
        count_d  = clr_i ? '0 : step_i ? (wrap_o ? '0 : count_q + 1'b1) : count_q;
        count_x  = {2'b00, count_d};
        sync_lo  = {2'b00, active_i} + {2'b00, fp_i};
        sync_hi  = sync_lo + {2'b00, sync_i};
        active_o = count_d < active_i;
        sync_o   = count_x >= sync_lo && count_x < sync_hi;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing source with a frame-boundary
// shadow config so mode changes never tear a frame.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int X_BITS = VTG_X_BITS,
    parameter int Y_BITS = VTG_Y_BITS
) (
    input logic                clk_in,
    input logic                reset_n,
    video_timing_gen_if.master vif
);
    vtg_state_e        state_q, state_d;
    vtg_cfg_t          cfg_in, cfg_q, cfg_d, shd_q, shd_d;
    logic [X_BITS-1:0] x_cnt;
    logic [Y_BITS-1:0] y_cnt;
    logic              h_wrap, v_wrap, h_act, v_act, h_sy, v_sy;
    logic              run_q, run_d, ld, apply, frame_end;
    logic              den_q, den_d, hn_q, hn_d, vn_q, vn_d, fs_q, fs_d, err_q, err_d;

    always_comb begin
        cfg_in = '{h_total: vif.cfg_h_total, h_active: vif.cfg_h_active,
                   h_fp: vif.cfg_h_fp, h_sync: vif.cfg_h_sync,
                   v_total: vif.cfg_v_total, v_active: vif.cfg_v_active,
                   v_fp: vif.cfg_v_fp, v_sync: vif.cfg_v_sync,
                   hs_pol: vif.cfg_hs_pol, vs_pol: vif.cfg_vs_pol};
        run_q     = state_q != ST_STOP;
        ld        = vif.cfg_load && vtg_cfg_ok(cfg_in);
        err_d     = vif.cfg_load && !vtg_cfg_ok(cfg_in);
        frame_end = run_q && h_wrap && v_wrap;
        apply     = (!run_q && ld) || (frame_end && (ld || state_q == ST_PEND));
        state_d   = apply ? ST_RUN : (run_q && ld) ? ST_PEND : state_q;
        cfg_d     = apply ? (ld ? cfg_in : shd_q) : cfg_q;
        shd_d     = ld ? cfg_in : shd_q;
        run_d     = state_d != ST_STOP;
        fs_d      = apply || frame_end;
    end

    // STOP is only reachable through reset, so holding the syncs keeps them at reset level.
    always_comb begin
        den_d = h_act && v_act;
        hn_d  = run_d ? h_sy == cfg_d.hs_pol : hn_q;
        vn_d  = run_d ? v_sy == cfg_d.vs_pol : vn_q;
    end

    vtg_axis_counter #(.W(X_BITS)) u_h (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .clr_i   (apply),
        .step_i  (run_q),
        .total_i (cfg_q.h_total),
        .active_i(cfg_d.h_active),
        .fp_i    (cfg_d.h_fp),
        .sync_i  (cfg_d.h_sync),
        .count_o (x_cnt),
        .wrap_o  (h_wrap),
        .active_o(h_act),
        .sync_o  (h_sy)
    );

    vtg_axis_counter #(.W(Y_BITS)) u_v (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .clr_i   (apply),
        .step_i  (run_q && h_wrap),
        .total_i (cfg_q.v_total),
        .active_i(cfg_d.v_active),
        .fp_i    (cfg_d.v_fp),
        .sync_i  (cfg_d.v_sync),
        .count_o (y_cnt),
        .wrap_o  (v_wrap),
        .active_o(v_act),
        .sync_o  (v_sy)
    );

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_STOP;
            cfg_q   <= '0;
            shd_q   <= '0;
            den_q   <= 1'b0;
            hn_q    <= 1'b0;
            vn_q    <= 1'b0;
            fs_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            shd_q   <= shd_d;
            den_q   <= den_d;
            hn_q    <= hn_d;
            vn_q    <= vn_d;
            fs_q    <= fs_d;
            err_q   <= err_d;
        end
    end

    assign vif.x                  = x_cnt;
    assign vif.y                  = y_cnt;
    assign vif.den_out            = den_q;
    assign vif.hn_out             = hn_q;
    assign vif.vn_out             = vn_q;
    assign vif.frame_start        = fs_q;
    assign vif.cfg_err            = err_q;
    assign vif.cfg_pending        = state_q == ST_PEND;
    assign vif.total_active_pix   = cfg_q.h_active;
    assign vif.total_active_lines = cfg_q.v_active;
endmodule
